rnds_dispatch_buffer: RTL and testbench

- Parametrised N-wide dispatch buffer between rename and the issue queues (IQs). It replaces the fixed 2-wide direct dispatch and its two-level free-entry handshake.
- Renamed micro-ops enter as an in-order group. They are held in a circular buffer and drained in program order, up to DISP_WIDTH per cycle, to NUM_IQ IQs.
- Dispatch is gated by per-IQ credit counters and by ROB allocation availability. A flush empties the buffer and restores all credits.

---
 rtl/rnds_dispatch_buffer_pkg.sv | 23 ++
 rtl/rnds_dispatch_buffer_credit_counter.sv | 45 ++++
 rtl/rnds_dispatch_buffer.sv | 163 ++++++++++++++++
 tb/tb_rnds_dispatch_buffer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rnds_dispatch_buffer_pkg.sv
// Purpose:      shared defaults and types for the rename-to-IQ dispatch buffer.
// Latency:      n/a (types and constants only).
// Backpressure: n/a.
package rnds_dispatch_buffer_pkg;

    localparam int DISP_WIDTH_DEF = 2;
    localparam int NUM_IQ_DEF     = 2;
    localparam int IQ_DEPTH_DEF   = 8;
    localparam int BUF_DEPTH_DEF  = 8;
    localparam int PACK_W_DEF     = 64;
    localparam int IQ_SEL_W_DEF   = $clog2(NUM_IQ_DEF);

    typedef enum logic [IQ_SEL_W_DEF-1:0] {
        IQ_INT = IQ_SEL_W_DEF'(0),
        IQ_MEM = IQ_SEL_W_DEF'(1)
    } iq_sel_t;

    typedef struct packed {
        logic [PACK_W_DEF-1:0] payload;
        iq_sel_t               iq_sel;
    } dispatch_slot_t;

endpackage

// File: rtl/rnds_dispatch_buffer_credit_counter.sv
// Purpose:      free-entry credit counter for one issue queue.
// Latency:      1 cycle; dispatch and release both land in the next-cycle value.
// Backpressure: none; the counter is what the dispatcher uses to throttle itself.
// Ports: clk/rst (sync, active high), flush (restore to IQ_DEPTH),
//        disp_cnt (lanes dispatched to this IQ), rel_cnt (entries freed), credit (current value).
module rnds_dispatch_buffer_credit_counter
    import rnds_dispatch_buffer_pkg::*;
#(
    parameter int IQ_DEPTH = IQ_DEPTH_DEF,
    parameter int CNT_W    = 2,
    parameter int CRED_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [CNT_W-1:0]  disp_cnt,
    input  logic [CNT_W-1:0]  rel_cnt,
    output logic [CRED_W-1:0] credit
);

    logic [CRED_W-1:0] credit_q, credit_d;

    always_comb begin
        if (flush) begin
            credit_d = CRED_W'(IQ_DEPTH);
        end else begin
            credit_d = credit_q - CRED_W'(disp_cnt) + CRED_W'(rel_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= CRED_W'(IQ_DEPTH);
        end else begin
            credit_q <= credit_d;
            // The IQ can never free more entries than it has handed out.
            if (!flush) begin
                assert (int'(credit_q) - int'(disp_cnt) + int'(rel_cnt) <= IQ_DEPTH);
            end
        end
    end

    assign credit = credit_q;

endmodule

// File: rtl/rnds_dispatch_buffer.sv
// Purpose:      N-wide in-order circular buffer from rename to the issue queues.
// Latency:      1 cycle enqueue-to-dispatch; dispatch is combinational from registered state.
// Backpressure: enq_ready needs DISP_WIDTH free slots; dispatch gated by IQ credits and rob_avail.
// Ports: enq_* (prefix-valid group in), deq_* (prefix-valid dispatch out, also ROB alloc),
//        rob_avail, iq_release (per-IQ frees), iq_credit (debug), buf_count (occupancy), flush.
module rnds_dispatch_buffer
    import rnds_dispatch_buffer_pkg::*;
#(
    parameter  int DISP_WIDTH = DISP_WIDTH_DEF,
    parameter  int NUM_IQ     = NUM_IQ_DEF,
    parameter  int IQ_DEPTH   = IQ_DEPTH_DEF,
    parameter  int BUF_DEPTH  = BUF_DEPTH_DEF,
    parameter  int PACK_W     = PACK_W_DEF,
    localparam int IQ_SEL_W   = $clog2(NUM_IQ),
    localparam int CNT_W      = $clog2(DISP_WIDTH + 1),
    localparam int CRED_W     = $clog2(IQ_DEPTH + 1),
    localparam int BCNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [DISP_WIDTH-1:0]          enq_valid,
    input  logic [DISP_WIDTH*PACK_W-1:0]   enq_pack,
    input  logic [DISP_WIDTH*IQ_SEL_W-1:0] enq_iq_sel,
    output logic                           enq_ready,
    input  logic [CNT_W-1:0]               rob_avail,
    input  logic [NUM_IQ*CNT_W-1:0]        iq_release,
    output logic [DISP_WIDTH-1:0]          deq_valid,
    output logic [DISP_WIDTH*PACK_W-1:0]   deq_pack,
    output logic [DISP_WIDTH*IQ_SEL_W-1:0] deq_iq_sel,
    output logic [NUM_IQ*CRED_W-1:0]       iq_credit,
    output logic [BCNT_W-1:0]              buf_count
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    logic [PACK_W-1:0]   pack_q [BUF_DEPTH];
    logic [PACK_W-1:0]   pack_d [BUF_DEPTH];
    logic [IQ_SEL_W-1:0] sel_q  [BUF_DEPTH];
    logic [IQ_SEL_W-1:0] sel_d  [BUF_DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [BCNT_W-1:0]   buf_count_q, buf_count_d;

    logic [CRED_W-1:0]   credit   [NUM_IQ];
    logic [CNT_W-1:0]    disp_cnt [NUM_IQ];
    logic [CNT_W-1:0]    rel_cnt  [NUM_IQ];
    logic [CNT_W-1:0]    enq_n, deq_n;
    logic                kill, do_enq;

    // Reset mid-run behaves as a flush for the combinational side.
    assign kill      = rst | flush;
    assign enq_ready = (int'(BUF_DEPTH) - int'(buf_count_q)) >= DISP_WIDTH;
    assign do_enq    = enq_ready & ~kill;
    assign buf_count = buf_count_q;

    // In-order dispatch: the first lane that fails any gate blocks every younger lane.
    // Credit is consumed lane by lane, so two lanes to one IQ need two credits.
    always_comb begin
        logic                blocked;
        logic [PTR_W-1:0]    idx;
        logic [IQ_SEL_W-1:0] s;
        deq_valid  = '0;
        deq_pack   = '0;
        deq_iq_sel = '0;
        deq_n      = '0;
        for (int k = 0; k < NUM_IQ; k++) begin
            disp_cnt[k] = '0;
        end
        blocked = kill;
        idx     = head_q;
        s       = '0;
        for (int i = 0; i < DISP_WIDTH; i++) begin
            idx = head_q + PTR_W'(i);
            s   = sel_q[idx];
            if (!blocked && (i < int'(buf_count_q)) && (i < int'(rob_avail)) &&
                (int'(credit[s]) > int'(disp_cnt[s]))) begin
                deq_valid[i]                          = 1'b1;
                deq_pack[i*PACK_W +: PACK_W]          = pack_q[idx];
                deq_iq_sel[i*IQ_SEL_W +: IQ_SEL_W]    = s;
                disp_cnt[s]                           = disp_cnt[s] + CNT_W'(1);
                deq_n                                 = deq_n + CNT_W'(1);
            end else begin
                blocked = 1'b1;
            end
        end
    end

    // Valid lanes form a prefix, so lane i always lands at tail+i.
    always_comb begin
        pack_d = pack_q;
        sel_d  = sel_q;
        enq_n  = '0;
        for (int i = 0; i < DISP_WIDTH; i++) begin
            if (do_enq && enq_valid[i]) begin
                pack_d[tail_q + PTR_W'(i)] = enq_pack[i*PACK_W +: PACK_W];
                sel_d[tail_q + PTR_W'(i)]  = enq_iq_sel[i*IQ_SEL_W +: IQ_SEL_W];
                enq_n                      = enq_n + CNT_W'(1);
            end
        end
    end

    always_comb begin
        if (kill) begin
            head_d      = '0;
            tail_d      = '0;
            buf_count_d = '0;
        end else begin
            head_d      = head_q + PTR_W'(deq_n);
            tail_d      = tail_q + PTR_W'(enq_n);
            buf_count_d = buf_count_q + BCNT_W'(enq_n) - BCNT_W'(deq_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            buf_count_q <= '0;
            for (int j = 0; j < BUF_DEPTH; j++) begin
                pack_q[j] <= '0;
                sel_q[j]  <= '0;
            end
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            buf_count_q <= buf_count_d;
            pack_q      <= pack_d;
            sel_q       <= sel_d;
        end
    end

    for (genvar k = 0; k < NUM_IQ; k++) begin : g_cred
        assign rel_cnt[k] = iq_release[k*CNT_W +: CNT_W];

        rnds_dispatch_buffer_credit_counter #(
            .IQ_DEPTH (IQ_DEPTH),
            .CNT_W    (CNT_W),
            .CRED_W   (CRED_W)
        ) u_credit (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .disp_cnt (disp_cnt[k]),
            .rel_cnt  (rel_cnt[k]),
            .credit   (credit[k])
        );

        assign iq_credit[k*CRED_W +: CRED_W] = credit[k];
    end

    // Interface legality checks on upstream/downstream behaviour.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((enq_valid & (enq_valid + DISP_WIDTH'(1))) == '0);
            assert (int'(rob_avail) <= DISP_WIDTH);
            assert (int'(buf_count_q) <= BUF_DEPTH);
            for (int k = 0; k < NUM_IQ; k++) begin
                assert (int'(rel_cnt[k]) <= DISP_WIDTH);
            end
        end
    end

endmodule

// File: tb/tb_rnds_dispatch_buffer.sv
// Purpose:      directed plus randomized bench for the dispatch buffer against a queue model.
// Latency:      inputs applied 1 time unit after posedge, outputs sampled on the negedge.
// Backpressure: model honours enq_ready; releases are bounded so credits stay legal.
module tb_rnds_dispatch_buffer;
    import rnds_dispatch_buffer_pkg::*;

    localparam int DW    = 2;
    localparam int NIQ   = 2;
    localparam int IQD   = 8;
    localparam int BD    = 8;
    localparam int PW    = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [1:0]    enq_valid;
    logic [127:0]  enq_pack;
    logic [1:0]    enq_iq_sel;
    logic          enq_ready;
    logic [1:0]    rob_avail;
    logic [3:0]    iq_release;
    logic [1:0]    deq_valid;
    logic [127:0]  deq_pack;
    logic [1:0]    deq_iq_sel;
    logic [7:0]    iq_credit;
    logic [3:0]    buf_count;

    int            checks = 0;
    int            errors = 0;
    logic [1:0]    last_deq;

    // Model: a program-order queue of pending micro-ops and one integer credit per IQ.
    dispatch_slot_t mq[$];
    int             cred[NIQ];

    rnds_dispatch_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .enq_valid  (enq_valid),
        .enq_pack   (enq_pack),
        .enq_iq_sel (enq_iq_sel),
        .enq_ready  (enq_ready),
        .rob_avail  (rob_avail),
        .iq_release (iq_release),
        .deq_valid  (deq_valid),
        .deq_pack   (deq_pack),
        .deq_iq_sel (deq_iq_sel),
        .iq_credit  (iq_credit),
        .buf_count  (buf_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_enq(input logic [1:0] v, input logic s0, input logic s1);
        enq_valid  = v;
        enq_pack   = {$urandom, $urandom, $urandom, $urandom};
        enq_iq_sel = {s1, s0};
    endtask

    // One clock: compare the DUT against the model at the negedge, then advance the model.
    task automatic tick();
        int n;
        int used[NIQ];
        bit exp_rdy;
        int s;
        dispatch_slot_t e;
        @(negedge clk);
        exp_rdy = (BD - mq.size()) >= DW;
        n = 0;
        used[0] = 0;
        used[1] = 0;
        if (!(rst || flush)) begin
            while (n < DW && n < mq.size() && n < int'(rob_avail)) begin
                s = int'(mq[n].iq_sel);
                if (cred[s] - used[s] <= 0) break;
                used[s]++;
                n++;
            end
        end
        chk("deq_valid", 64'(deq_valid), 64'((1 << n) - 1));
        last_deq = deq_valid;
        for (int l = 0; l < DW; l++) begin
            chk($sformatf("deq_pack%0d", l), deq_pack[l*PW +: PW], (l < n) ? mq[l].payload : 64'd0);
            chk($sformatf("deq_sel%0d", l), 64'(deq_iq_sel[l]), (l < n) ? 64'(mq[l].iq_sel) : 64'd0);
        end
        chk("enq_ready", 64'(enq_ready), 64'(exp_rdy));
        chk("buf_count", 64'(buf_count), 64'(mq.size()));
        for (int k = 0; k < NIQ; k++) begin
            chk($sformatf("iq_credit%0d", k), 64'(iq_credit[k*4 +: 4]), 64'(cred[k]));
        end
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
            cred[0] = IQD;
            cred[1] = IQD;
        end else begin
            for (int i = 0; i < n; i++) void'(mq.pop_front());
            for (int k = 0; k < NIQ; k++) cred[k] += int'(iq_release[k*2 +: 2]) - used[k];
            if (exp_rdy) begin
                for (int l = 0; l < DW; l++) begin
                    if (enq_valid[l]) begin
                        e.payload = enq_pack[l*PW +: PW];
                        e.iq_sel  = iq_sel_t'(enq_iq_sel[l]);
                        mq.push_back(e);
                    end
                end
            end
        end
        #1;
    endtask

    function automatic logic [1:0] legal_rel(input int c);
        int m;
        m = (IQD - c > 2) ? 2 : IQD - c;
        return 2'($urandom_range(0, m));
    endfunction

    // Empty the buffer and bring both IQs back to full credit, bounded.
    task automatic drain_restore();
        int guard = 0;
        enq_valid = '0;
        rob_avail = 2'd2;
        flush     = 1'b0;
        while ((mq.size() != 0 || cred[0] != IQD || cred[1] != IQD) && guard < 40) begin
            iq_release = {2'((IQD - cred[1] > 2) ? 2 : IQD - cred[1]),
                          2'((IQD - cred[0] > 2) ? 2 : IQD - cred[0])};
            tick();
            guard++;
        end
        chk("drain_bound", 64'(guard < 40), 64'd1);
        iq_release = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; enq_valid = '0; enq_pack = '0; enq_iq_sel = '0;
        rob_avail = '0; iq_release = '0; last_deq = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        cred[0] = IQD;
        cred[1] = IQD;

        // Reset state
        chk("rst_count", 64'(buf_count), 64'd0);
        chk("rst_ready", 64'(enq_ready), 64'd1);
        chk("rst_deq", 64'(deq_valid), 64'd0);
        chk("rst_pack", deq_pack[63:0], 64'd0);
        chk("rst_cred_int", 64'(iq_credit[3:0]), 64'd8);
        chk("rst_cred_mem", 64'(iq_credit[7:4]), 64'd8);

        // Two INT micro-ops dispatch together on the following cycle
        rob_avail = 2'd2;
        set_enq(2'b11, IQ_INT, IQ_INT); tick();
        set_enq(2'b00, IQ_INT, IQ_INT); tick();
        chk("t1_deq", 64'(last_deq), 64'd3);
        chk("t1_cred_int", 64'(iq_credit[3:0]), 64'd6);
        chk("t1_count", 64'(buf_count), 64'd0);
        drain_restore();

        // Fill with MEM while the ROB is full; ready drops at 8 and also at 7
        rob_avail = 2'd0;
        for (int i = 0; i < 4; i++) begin
            set_enq(2'b11, IQ_MEM, IQ_MEM); tick();
        end
        chk("t2_count8", 64'(buf_count), 64'd8);
        chk("t2_ready8", 64'(enq_ready), 64'd0);
        chk("t2_deq", 64'(last_deq), 64'd0);
        tick();
        chk("t2_held", 64'(buf_count), 64'd8);
        set_enq(2'b00, IQ_INT, IQ_INT);
        rob_avail = 2'd1; tick();
        chk("t2_count7", 64'(buf_count), 64'd7);
        chk("t2_ready7", 64'(enq_ready), 64'd0);
        drain_restore();

        // INT credit of one with {INT,INT} at head, then a release frees the next lane
        rob_avail = 2'd0;
        for (int i = 0; i < 4; i++) begin
            set_enq(2'b11, IQ_INT, IQ_INT); tick();
        end
        set_enq(2'b00, IQ_INT, IQ_INT);
        rob_avail = 2'd2;
        for (int i = 0; i < 3; i++) tick();
        rob_avail = 2'd1;
        set_enq(2'b11, IQ_INT, IQ_INT); tick();
        chk("t3_cred1", 64'(iq_credit[3:0]), 64'd1);
        set_enq(2'b00, IQ_INT, IQ_INT);
        rob_avail = 2'd2; tick();
        chk("t3_deq_one", 64'(last_deq), 64'd1);
        iq_release = 4'b0001; tick();
        chk("t3_deq_none", 64'(last_deq), 64'd0);
        iq_release = 4'b0000; tick();
        chk("t3_deq_after_rel", 64'(last_deq), 64'd1);
        drain_restore();

        // MEM credit exhausted: {INT,MEM} gives one lane, {MEM,INT} gives none
        rob_avail = 2'd0;
        for (int i = 0; i < 4; i++) begin
            set_enq(2'b11, IQ_MEM, IQ_MEM); tick();
        end
        set_enq(2'b00, IQ_INT, IQ_INT);
        rob_avail = 2'd2;
        for (int i = 0; i < 4; i++) tick();
        chk("t4_cred_mem0", 64'(iq_credit[7:4]), 64'd0);
        rob_avail = 2'd0;
        set_enq(2'b11, IQ_INT, IQ_MEM); tick();
        set_enq(2'b11, IQ_INT, IQ_INT); tick();
        set_enq(2'b00, IQ_INT, IQ_INT);
        rob_avail = 2'd2; tick();
        chk("t4_int_mem", 64'(last_deq), 64'd1);
        tick();
        chk("t4_mem_int", 64'(last_deq), 64'd0);
        drain_restore();

        // ROB limited to one per cycle across a pointer wrap
        rob_avail = 2'd0;
        set_enq(2'b11, 1'($urandom), 1'($urandom)); tick();
        set_enq(2'b11, 1'($urandom), 1'($urandom)); tick();
        set_enq(2'b00, IQ_INT, IQ_INT);
        rob_avail = 2'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t5_deq%0d", i), 64'(last_deq), 64'd1);
        end
        chk("t5_count", 64'(buf_count), 64'd0);
        drain_restore();

        // Flush beats a same-cycle enqueue, release and dispatch
        rob_avail = 2'd0;
        set_enq(2'b11, IQ_INT, IQ_INT); tick();
        set_enq(2'b11, IQ_INT, IQ_INT); tick();
        set_enq(2'b00, IQ_INT, IQ_INT);
        rob_avail = 2'd2; tick(); tick();
        chk("t6_cred4", 64'(iq_credit[3:0]), 64'd4);
        rob_avail = 2'd0;
        set_enq(2'b11, IQ_INT, IQ_MEM); tick();
        flush = 1'b1; rob_avail = 2'd2; iq_release = 4'b0010;
        set_enq(2'b11, IQ_INT, IQ_INT); tick();
        chk("t6_deq_flush", 64'(last_deq), 64'd0);
        flush = 1'b0; iq_release = '0;
        set_enq(2'b00, IQ_INT, IQ_INT);
        chk("t6_count", 64'(buf_count), 64'd0);
        chk("t6_cred_int", 64'(iq_credit[3:0]), 64'd8);
        chk("t6_cred_mem", 64'(iq_credit[7:4]), 64'd8);
        tick();
        chk("t6_dropped", 64'(last_deq), 64'd0);

        // Reset in the middle of traffic
        rob_avail = 2'd0;
        set_enq(2'b11, IQ_MEM, IQ_INT); tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        set_enq(2'b00, IQ_INT, IQ_INT);
        chk("mid_rst_count", 64'(buf_count), 64'd0);
        chk("mid_rst_ready", 64'(enq_ready), 64'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 500; c++) begin
            case ($urandom_range(0, 2))
                0:       set_enq(2'b00, 1'($urandom), 1'($urandom));
                1:       set_enq(2'b01, 1'($urandom), 1'($urandom));
                default: set_enq(2'b11, 1'($urandom), 1'($urandom));
            endcase
            rob_avail  = 2'($urandom_range(0, 2));
            iq_release = {legal_rel(cred[1]), legal_rel(cred[0])};
            flush      = ($urandom_range(0, 31) == 0);
            rst        = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0;
        drain_restore();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
